// File: rtl/mpi_stream_interface.sv
// MPI message framer: emits four header flits then passes payload through on TX,
// and detects done frames on RX that complete an outstanding WAIT_DONE command.
module mpi_stream_interface #(
  parameter logic [15:0] ETHERTYPE = 16'h7400,
  parameter logic [7:0]  OP_SEND   = 8'h01,
  parameter logic [7:0]  OP_DONE   = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [15:0] cmd_dst_rank,
  input  logic [7:0]  cmd_src_rank,
  input  logic [31:0] cmd_size,
  input  logic [47:0] cmd_mac_dst,
  input  logic [47:0] cmd_mac_src,
  input  logic [31:0] cmd_ip_dst,
  input  logic [31:0] cmd_ip_src,
  input  logic [63:0] pay_data,
  input  logic [7:0]  pay_keep,
  input  logic        pay_last,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [63:0] stream_out_data,
  output logic [7:0]  stream_out_keep,
  output logic        stream_out_last,
  output logic        stream_out_valid,
  input  logic        stream_out_ready,
  input  logic [63:0] stream_in_data,
  input  logic [7:0]  stream_in_keep,
  input  logic        stream_in_last,
  input  logic        stream_in_valid,
  output logic        stream_in_ready,
  output logic        done,
  output logic [2:0]  dbg_state
);

  // Every stream and the command port: a beat transfers on a rising edge with
  // valid && ready; the source holds data/keep/last stable while valid && !ready.

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_HDR2    = 3'd3,
    ST_HDR3    = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_WAIT    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dst_rank_q, dst_rank_d;
  logic [7:0]  src_rank_q, src_rank_d;
  logic [31:0] size_q, size_d;
  logic [47:0] mac_dst_q, mac_dst_d;
  logic [47:0] mac_src_q, mac_src_d;
  logic [31:0] ip_dst_q, ip_dst_d;
  logic [31:0] ip_src_q, ip_src_d;
  logic [63:0] hdr_data_q, hdr_data_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic        rx_ok0_q, rx_ok0_d;
  logic        rx_ok3_q, rx_ok3_d;
  logic        rx_past3_q, rx_past3_d;
  logic        done_pending_q, done_pending_d;

  logic in_payload, cmd_fire, consume;
  logic rx_beat, hit0, hit3, ok3_eff, rx_match;
  logic unused_rx;

  assign in_payload = (state_q == ST_PAYLOAD);
  assign cmd_ready  = (state_q == ST_IDLE) && !reset;
  assign cmd_fire   = cmd_valid && cmd_ready;

  assign stream_out_data  = in_payload ? pay_data  : hdr_data_q;
  assign stream_out_keep  = in_payload ? pay_keep  : (hdr_valid_q ? 8'hff : 8'h00);
  assign stream_out_last  = in_payload && pay_last;
  assign stream_out_valid = in_payload ? pay_valid : hdr_valid_q;
  assign pay_ready        = in_payload && stream_out_ready;

  assign done      = (state_q == ST_WAIT) && done_pending_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    dst_rank_d  = dst_rank_q;
    src_rank_d  = src_rank_q;
    size_d      = size_q;
    mac_dst_d   = mac_dst_q;
    mac_src_d   = mac_src_q;
    ip_dst_d    = ip_dst_q;
    ip_src_d    = ip_src_q;
    hdr_data_d  = hdr_data_q;
    hdr_valid_d = hdr_valid_q;
    consume     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          dst_rank_d = cmd_dst_rank;
          src_rank_d = cmd_src_rank;
          size_d     = cmd_size;
          mac_dst_d  = cmd_mac_dst;
          mac_src_d  = cmd_mac_src;
          ip_dst_d   = cmd_ip_dst;
          ip_src_d   = cmd_ip_src;
          if (!cmd_op) begin
            // H0 is built from the command inputs so it is ready the next cycle.
            hdr_data_d  = {cmd_mac_dst, cmd_mac_src[47:32]};
            hdr_valid_d = 1'b1;
            state_d     = ST_HDR0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_HDR0: if (stream_out_ready) begin
        hdr_data_d = {mac_src_q[31:0], ETHERTYPE, dst_rank_q};
        state_d    = ST_HDR1;
      end
      ST_HDR1: if (stream_out_ready) begin
        hdr_data_d = {ip_dst_q, ip_src_q};
        state_d    = ST_HDR2;
      end
      ST_HDR2: if (stream_out_ready) begin
        hdr_data_d = {dst_rank_q, src_rank_q, OP_SEND, size_q};
        state_d    = ST_HDR3;
      end
      ST_HDR3: if (stream_out_ready) begin
        hdr_data_d  = 64'h0;
        hdr_valid_d = 1'b0;
        state_d     = ST_PAYLOAD;
      end
      ST_PAYLOAD: if (pay_valid && stream_out_ready && pay_last) state_d = ST_IDLE;
      ST_WAIT: if (done_pending_q) begin
        consume = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stream_in_ready = !reset;
  assign rx_beat = stream_in_valid && stream_in_ready;
  assign hit0    = (stream_in_data[63:16] == mac_src_q);
  assign hit3    = (stream_in_data[63:48] == {8'h00, src_rank_q}) &&
                   (stream_in_data[47:40] == dst_rank_q[7:0]) &&
                   (stream_in_data[39:32] == OP_DONE);
  // Flit 3 may be the last beat itself, so its compare is used directly then.
  assign ok3_eff  = rx_past3_q ? rx_ok3_q : hit3;
  assign rx_match = rx_beat && stream_in_last && (rx_cnt_q == 2'd3) && rx_ok0_q && ok3_eff;
  assign unused_rx = ^{stream_in_keep, stream_in_data[15:0]};

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_ok0_d   = rx_ok0_q;
    rx_ok3_d   = rx_ok3_q;
    rx_past3_d = rx_past3_q;
    if (rx_beat) begin
      if (stream_in_last) begin
        rx_cnt_d   = 2'd0;
        rx_ok0_d   = 1'b0;
        rx_ok3_d   = 1'b0;
        rx_past3_d = 1'b0;
      end else begin
        if (rx_cnt_q == 2'd0) rx_ok0_d = hit0;
        if (rx_cnt_q == 2'd3 && !rx_past3_q) begin
          rx_ok3_d   = hit3;
          rx_past3_d = 1'b1;
        end
        if (rx_cnt_q != 2'd3) rx_cnt_d = rx_cnt_q + 2'd1;
      end
    end
    done_pending_d = rx_match || (done_pending_q && !consume);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      dst_rank_q     <= '0;
      src_rank_q     <= '0;
      size_q         <= '0;
      mac_dst_q      <= '0;
      mac_src_q      <= '0;
      ip_dst_q       <= '0;
      ip_src_q       <= '0;
      hdr_data_q     <= '0;
      hdr_valid_q    <= 1'b0;
      rx_cnt_q       <= '0;
      rx_ok0_q       <= 1'b0;
      rx_ok3_q       <= 1'b0;
      rx_past3_q     <= 1'b0;
      done_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dst_rank_q     <= dst_rank_d;
      src_rank_q     <= src_rank_d;
      size_q         <= size_d;
      mac_dst_q      <= mac_dst_d;
      mac_src_q      <= mac_src_d;
      ip_dst_q       <= ip_dst_d;
      ip_src_q       <= ip_src_d;
      hdr_data_q     <= hdr_data_d;
      hdr_valid_q    <= hdr_valid_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_ok0_q       <= rx_ok0_d;
      rx_ok3_q       <= rx_ok3_d;
      rx_past3_q     <= rx_past3_d;
      done_pending_q <= done_pending_d;
    end
  end

endmodule

// File: tb/tb_mpi_stream_interface.sv
// Directed bench for mpi_stream_interface: TX framing with stalls, RX done-frame
// matching from a vector table, pending/overlap corners and mid-payload reset.
module tb_mpi_stream_interface;

  localparam logic [15:0] SD = 16'd1;
  localparam logic [7:0]  SS = 8'd0;
  localparam logic [47:0] MD = 48'hfa163e55ca02;
  localparam logic [47:0] MS = 48'h0cc47a88c047;
  localparam logic [63:0] GOOD_F0 = 64'h0cc47a88c047_0800;
  localparam logic [63:0] GOOD_F3 = 64'h0000_01_02_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [15:0] cmd_dst_rank = '0;
  logic [7:0]  cmd_src_rank = '0;
  logic [31:0] cmd_size = '0;
  logic [47:0] cmd_mac_dst = '0, cmd_mac_src = '0;
  logic [31:0] cmd_ip_dst = '0, cmd_ip_src = '0;
  logic [63:0] pay_data = '0;
  logic [7:0]  pay_keep = '0;
  logic        pay_last = 1'b0, pay_valid = 1'b0, pay_ready;
  logic [63:0] stream_out_data;
  logic [7:0]  stream_out_keep;
  logic        stream_out_last, stream_out_valid;
  logic        stream_out_ready = 1'b1;
  logic [63:0] stream_in_data = '0;
  logic [7:0]  stream_in_keep = '0;
  logic        stream_in_last = 1'b0, stream_in_valid = 1'b0, stream_in_ready;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [72:0] exp_q[$];
  logic [72:0] pay_beats[$];
  logic        mon_en = 1'b1;
  logic        ready_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic [72:0] prev_flit = '0;

  always #5 clk = ~clk;

  mpi_stream_interface dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst_rank(cmd_dst_rank), .cmd_src_rank(cmd_src_rank), .cmd_size(cmd_size),
    .cmd_mac_dst(cmd_mac_dst), .cmd_mac_src(cmd_mac_src),
    .cmd_ip_dst(cmd_ip_dst), .cmd_ip_src(cmd_ip_src),
    .pay_data(pay_data), .pay_keep(pay_keep), .pay_last(pay_last),
    .pay_valid(pay_valid), .pay_ready(pay_ready),
    .stream_out_data(stream_out_data), .stream_out_keep(stream_out_keep),
    .stream_out_last(stream_out_last), .stream_out_valid(stream_out_valid),
    .stream_out_ready(stream_out_ready),
    .stream_in_data(stream_in_data), .stream_in_keep(stream_in_keep),
    .stream_in_last(stream_in_last), .stream_in_valid(stream_in_valid),
    .stream_in_ready(stream_in_ready),
    .done(done), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sink ready: constant 1, or toggling every cycle when ready_mode is set.
  always @(posedge clk) begin
    #1;
    if (ready_mode) stream_out_ready = ~stream_out_ready;
    else stream_out_ready = 1'b1;
  end

  // TX scoreboard plus hold-while-stalled check.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall)
        chk("stall_hold", {stream_out_valid, stream_out_last, stream_out_keep, stream_out_data},
            {1'b1, prev_flit});
      if (stream_out_valid && stream_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra: got flit %h expected none", stream_out_data);
        end else begin
          chk("tx_flit", {stream_out_last, stream_out_keep, stream_out_data}, exp_q.pop_front());
        end
      end
      prev_stall = stream_out_valid && !stream_out_ready;
      prev_flit  = {stream_out_last, stream_out_keep, stream_out_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(negedge clk) if (done) done_seen++;

  task automatic issue_cmd(input logic op, input logic [15:0] dst, input logic [7:0] src,
                           input logic [31:0] size, input logic [47:0] macd,
                           input logic [47:0] macs, input logic [31:0] ipd,
                           input logic [31:0] ips);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_op = op; cmd_dst_rank = dst; cmd_src_rank = src; cmd_size = size;
    cmd_mac_dst = macd; cmd_mac_src = macs; cmd_ip_dst = ipd; cmd_ip_src = ips;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("first_hdr_valid", stream_out_valid, (op == 1'b0));
  endtask

  task automatic drive_payload();
    for (int i = 0; i < pay_beats.size(); i++) begin
      int n;
      logic acc;
      n = 0;
      acc = 1'b0;
      {pay_last, pay_keep, pay_data} = pay_beats[i];
      pay_valid = 1'b1;
      while (!acc && n < 200) begin
        @(negedge clk);
        if (pay_ready) acc = 1'b1;
        n++;
      end
      chk("pay_accept", acc, 1);
      @(posedge clk);
      #1;
    end
    pay_valid = 1'b0;
    pay_last  = 1'b0;
  endtask

  task automatic do_send(input logic [15:0] dst, input logic [7:0] src, input logic [31:0] size,
                         input logic [47:0] macd, input logic [47:0] macs,
                         input logic [31:0] ipd, input logic [31:0] ips);
    exp_q.push_back({1'b0, 8'hff, macd, macs[47:32]});
    exp_q.push_back({1'b0, 8'hff, macs[31:0], 16'h7400, dst});
    exp_q.push_back({1'b0, 8'hff, ipd, ips});
    exp_q.push_back({1'b0, 8'hff, dst, src, 8'h01, size});
    foreach (pay_beats[i]) exp_q.push_back(pay_beats[i]);
    issue_cmd(1'b0, dst, src, size, macd, macs, ipd, ips);
    drive_payload();
    @(negedge clk);
    chk("send_back_idle", {dbg_state, cmd_ready}, {3'd0, 1'b1});
    chk("send_all_flits", exp_q.size(), 0);
  endtask

  task automatic inject_frame(input logic [63:0] f0, input logic [63:0] f3, input int n);
    for (int i = 0; i < n; i++) begin
      stream_in_valid = 1'b1;
      stream_in_keep  = 8'hff;
      stream_in_last  = (i == n - 1);
      stream_in_data  = (i == 0) ? f0 : (i == 3) ? f3 : (64'h1111_2222_3333_0000 + 64'(i));
      @(posedge clk);
      #1;
    end
    stream_in_valid = 1'b0;
    stream_in_last  = 1'b0;
  endtask

  typedef struct {
    logic [63:0] f0;
    logic [63:0] f3;
    int          n;
    logic        exp_done;
  } rx_vec_t;

  rx_vec_t rx_tab[8];

  initial begin
    int base;
    logic in_wait;
    int n;

    rx_tab[0] = '{GOOD_F0, GOOD_F3, 5, 1'b1};
    rx_tab[1] = '{GOOD_F0, 64'h0000_01_03_0000_0000, 5, 1'b0};
    rx_tab[2] = '{GOOD_F0, GOOD_F3, 3, 1'b0};
    rx_tab[3] = '{64'h0cc47a88c048_0800, GOOD_F3, 5, 1'b0};
    rx_tab[4] = '{GOOD_F0, 64'h0000_02_02_0000_0000, 4, 1'b0};
    rx_tab[5] = '{GOOD_F0, 64'h0001_01_02_0000_0000, 4, 1'b0};
    rx_tab[6] = '{GOOD_F0, GOOD_F3, 4, 1'b1};
    rx_tab[7] = '{GOOD_F0, GOOD_F3, 6, 1'b1};

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("in_reset_ready", {cmd_ready, stream_in_ready, pay_ready, done}, 4'b0000);
    chk("in_reset_out", {stream_out_valid, stream_out_last, stream_out_keep, stream_out_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {cmd_ready, stream_in_ready, pay_ready, done}, 4'b1100);
    chk("post_reset_state", {dbg_state, stream_out_valid, stream_out_data}, 0);

    // SEND with sink ready toggling every cycle
    ready_mode = 1'b1;
    pay_beats = '{ {1'b0, 8'hff, 64'hdead_beef_0000_0001}, {1'b1, 8'h0f, 64'hdead_beef_0000_0002} };
    do_send(16'h1234, 8'h56, 32'd3, 48'ha1a2a3a4a5a6, 48'hb1b2b3b4b5b6, 32'h0a000001, 32'h0a000002);
    ready_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reference SEND
    pay_beats = '{ {1'b1, 8'hff, 64'h8} };
    exp_q.push_back({1'b0, 8'hff, 64'hfa163e55ca020cc4});
    exp_q.push_back({1'b0, 8'hff, 64'h7a88c047_7400_0001});
    exp_q.push_back({1'b0, 8'hff, 64'h0});
    exp_q.push_back({1'b0, 8'hff, 64'h0001_00_01_00000002});
    exp_q.push_back({1'b1, 8'hff, 64'h8});
    issue_cmd(1'b0, SD, SS, 32'd2, MD, MS, 32'h0, 32'h0);
    drive_payload();
    @(negedge clk);
    chk("ref_back_idle", {dbg_state, cmd_ready}, {3'd0, 1'b1});
    chk("ref_all_flits", exp_q.size(), 0);

    // RX vector table, all within WAIT
    in_wait = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (!in_wait) begin
        issue_cmd(1'b1, SD, SS, 32'd0, MD, MS, 32'h0, 32'h0);
        in_wait = 1'b1;
      end
      base = done_seen;
      inject_frame(rx_tab[v].f0, rx_tab[v].f3, rx_tab[v].n);
      @(negedge clk);
      chk($sformatf("rx%0d_done_latency", v), done, rx_tab[v].exp_done);
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("rx%0d_pulses", v), done_seen - base, rx_tab[v].exp_done);
      if (rx_tab[v].exp_done) begin
        chk($sformatf("rx%0d_cmd_ready", v), cmd_ready, 1);
        in_wait = 1'b0;
      end
    end

    // Done frame ahead of WAIT_DONE is held
    base = done_seen;
    inject_frame(GOOD_F0, GOOD_F3, 4);
    repeat (3) @(negedge clk);
    #1;
    chk("held_no_done", done_seen - base, 0);
    issue_cmd(1'b1, SD, SS, 32'd0, MD, MS, 32'h0, 32'h0);
    @(negedge clk);
    chk("held_done_latency", done, 1);
    @(negedge clk);
    chk("held_done_one_cycle", {done, cmd_ready}, 2'b01);

    // New match on the cycle pending is consumed stays pending
    inject_frame(GOOD_F0, GOOD_F3, 4);
    @(negedge clk);
    base = done_seen;
    fork
      inject_frame(GOOD_F0, GOOD_F3, 4);
      begin
        repeat (2) @(posedge clk);
        #1;
        issue_cmd(1'b1, SD, SS, 32'd0, MD, MS, 32'h0, 32'h0);
      end
    join
    #1;
    chk("overlap_one_pulse", done_seen - base, 1);
    issue_cmd(1'b1, SD, SS, 32'd0, MD, MS, 32'h0, 32'h0);
    @(negedge clk);
    chk("overlap_kept_pending", done, 1);

    // 18-beat payload ending in partial keep
    pay_beats.delete();
    for (int i = 0; i < 18; i++)
      pay_beats.push_back({(i == 17), (i == 17) ? 8'hf0 : 8'hff, 64'h0123_4567_0000_0000 + 64'(i)});
    do_send(16'h0002, 8'h03, 32'd36, MD, MS, 32'hc0a80001, 32'hc0a80002);

    // Reset in the middle of a payload
    mon_en = 1'b0;
    issue_cmd(1'b0, SD, SS, 32'd8, MD, MS, 32'h0, 32'h0);
    pay_valid = 1'b1; pay_keep = 8'hff; pay_last = 1'b0; pay_data = 64'hcafe_f00d_0000_0001;
    n = 0;
    while (!pay_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_payload", {pay_ready, stream_out_valid}, 2'b11);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_outputs", {stream_out_valid, stream_out_last, stream_out_keep, stream_out_data,
                          pay_ready, cmd_ready, stream_in_ready, done}, 0);
    pay_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_recovered", {dbg_state, cmd_ready, stream_out_valid}, {3'd0, 1'b1, 1'b0});
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
